// File: rtl/fish_pkg.sv
// Shared types and screen defaults for the fish position block.
// Build option: FISH_WRAP_EN (screen-edge wrap instead of escape).
package fish_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SWIM   = 2'd1,
    HOOKED = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    WAY_LEFT  = 2'd0,
    WAY_RIGHT = 2'd1,
    WAY_UP    = 2'd2,
    WAY_HOLD  = 2'd3
  } way_t;

  localparam int DEF_SCREEN_W = 640;
  localparam int DEF_SCREEN_H = 480;

  function automatic logic [9:0] clamp10(
    input logic [9:0] a,
    input logic [9:0] lim
  );
    return (a > lim) ? lim : a;
  endfunction

endpackage

// File: rtl/fish_if.sv
// Signal bundle between the fish mover/VGA side and fish_position.
// Build option: FISH_WRAP_EN affects only the escaped behaviour.
interface fish_if;
  logic [9:0] h;
  logic [9:0] v;
  logic [1:0] way;
  logic       appear;
  logic [2:0] hm;
  logic [2:0] vm;
  logic [9:0] spawn_x;
  logic [9:0] spawn_y;
  logic [9:0] hook_x;
  logic [9:0] hook_y;
  logic       hook_valid;
  logic [9:0] fish_x;
  logic [9:0] fish_y;
  logic       active;
  logic       in_fish;
  logic       caught;
  logic       landed;
  logic       escaped;

  modport master (
    output h, v, way, appear, hm, vm,
    output spawn_x, spawn_y,
    output hook_x, hook_y, hook_valid,
    input  fish_x, fish_y, active,
    input  in_fish, caught, landed, escaped
  );

  modport slave (
    input  h, v, way, appear, hm, vm,
    input  spawn_x, spawn_y,
    input  hook_x, hook_y, hook_valid,
    output fish_x, fish_y, active,
    output in_fish, caught, landed, escaped
  );
endinterface

// File: rtl/fish_box_hit.sv
// Point-in-rectangle test: (px,py) inside [bx,bx+W) x [by,by+H).
// Build option FISH_WRAP_EN has no effect here.
module fish_box_hit #(
  parameter int W = 32,
  parameter int H = 16
) (
  input  logic [9:0] i_px,
  input  logic [9:0] i_py,
  input  logic [9:0] i_bx,
  input  logic [9:0] i_by,
  output logic       o_hit
);
  logic [10:0] w_px, w_py;
  logic [10:0] w_bx, w_by;
  logic        w_hx, w_hy;

  assign w_px = {1'b0, i_px};
  assign w_py = {1'b0, i_py};
  assign w_bx = {1'b0, i_bx};
  assign w_by = {1'b0, i_by};

  assign w_hx = (w_px >= w_bx) &&
                (w_px < w_bx + 11'(W));
  assign w_hy = (w_py >= w_by) &&
                (w_py < w_by + 11'(H));
  assign o_hit = w_hx && w_hy;
endmodule

// File: rtl/fish_position.sv
// Fish position integrator and life cycle (IDLE/SWIM/HOOKED).
// Define FISH_WRAP_EN to wrap at screen edges instead of escaping.
module fish_position
  import fish_pkg::*;
#(
  parameter int SCREEN_W  = DEF_SCREEN_W,
  parameter int SCREEN_H  = DEF_SCREEN_H,
  parameter int FISH_W    = 32,
  parameter int FISH_H    = 16,
  parameter int REEL_STEP = 2
) (
  input logic  clk,
  input logic  rst,
  fish_if.slave bus
);
  localparam logic [10:0] XMAX =
    11'(SCREEN_W - FISH_W);
  localparam logic [10:0] YMAX =
    11'(SCREEN_H - FISH_H);

  state_t     r_state;
  logic [9:0] r_x, r_y;
  logic       r_caught;
  logic       r_landed;
  logic       r_escaped;
  logic       r_in_fish;

  logic        w_active;
  logic        w_hook_hit;
  logic        w_pix_hit;
  logic [10:0] w_x11, w_y11;
  logic [10:0] w_hm11, w_vm11;
  logic        w_bound;
  logic [9:0]  w_y_reel;

  assign w_active = (r_state != IDLE);
  assign w_x11  = {1'b0, r_x};
  assign w_y11  = {1'b0, r_y};
  assign w_hm11 = {8'b0, bus.hm};
  assign w_vm11 = {8'b0, bus.vm};

  always_comb begin
    w_bound = 1'b0;
    unique case (bus.way)
      WAY_LEFT:  w_bound = w_hm11 > w_x11;
      WAY_RIGHT: w_bound = (w_x11 + w_hm11) > XMAX;
      WAY_UP:    w_bound = w_vm11 > w_y11;
      default:   w_bound = 1'b0;
    endcase
  end

  // Saturating reel-up; landing is judged on this updated row
  assign w_y_reel = (r_y < 10'(REEL_STEP)) ?
    10'd0 : r_y - 10'(REEL_STEP);

  fish_box_hit #(.W(FISH_W), .H(FISH_H)) u_hook (
    .i_px (bus.hook_x),
    .i_py (bus.hook_y),
    .i_bx (r_x),
    .i_by (r_y),
    .o_hit(w_hook_hit)
  );

  fish_box_hit #(.W(FISH_W), .H(FISH_H)) u_pix (
    .i_px (bus.h),
    .i_py (bus.v),
    .i_bx (r_x),
    .i_by (r_y),
    .o_hit(w_pix_hit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_x       <= '0;
      r_y       <= '0;
      r_caught  <= 1'b0;
      r_landed  <= 1'b0;
      r_escaped <= 1'b0;
      r_in_fish <= 1'b0;
    end else begin
      r_caught  <= 1'b0;
      r_landed  <= 1'b0;
      r_escaped <= 1'b0;
      r_in_fish <= w_active && w_pix_hit;
      unique case (r_state)
        IDLE: begin
          if (bus.appear) begin
            r_x <= clamp10(bus.spawn_x, XMAX[9:0]);
            r_y <= clamp10(bus.spawn_y, YMAX[9:0]);
            r_state <= SWIM;
          end
        end
        SWIM: begin
          if (!bus.appear) begin
            r_state <= IDLE;
          end else if (bus.hook_valid && w_hook_hit) begin
            r_caught <= 1'b1;
            r_state  <= HOOKED;
          end else if (w_bound) begin
`ifdef FISH_WRAP_EN
            unique case (bus.way)
              WAY_LEFT:  r_x <= XMAX[9:0];
              WAY_RIGHT: r_x <= '0;
              WAY_UP:    r_y <= YMAX[9:0];
              default:   ;
            endcase
`else
            r_escaped <= 1'b1;
            r_state   <= IDLE;
`endif
          end else begin
            unique case (bus.way)
              WAY_LEFT:  r_x <= r_x - {7'b0, bus.hm};
              WAY_RIGHT: r_x <= r_x + {7'b0, bus.hm};
              WAY_UP:    r_y <= r_y - {7'b0, bus.vm};
              default:   ;
            endcase
          end
        end
        HOOKED: begin
          if (!bus.appear) begin
            r_state <= IDLE;
          end else if (bus.hm != 3'd0) begin
            r_y <= w_y_reel;
            if (w_y_reel == 10'd0) begin
              r_landed <= 1'b1;
              r_state  <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.fish_x  = r_x;
  assign bus.fish_y  = r_y;
  assign bus.active  = w_active;
  assign bus.in_fish = r_in_fish;
  assign bus.caught  = r_caught;
  assign bus.landed  = r_landed;
`ifdef FISH_WRAP_EN
  assign bus.escaped = 1'b0;
`else
  assign bus.escaped = r_escaped;
`endif
endmodule

// File: doc/fish_position.md
Name: fish_position

Overview:
- Consumer of the per-fish step outputs (hm, vm) produced by the fish movement generators.
- Integrates the step pulses into an on-screen fish position and runs the fish life cycle: idle, swimming, hooked and reeled up.
- Flags escape and catch events, and gives the VGA pixel path a registered "pixel is inside this fish" flag.
- One instance per fish, placed between the fish movement generator and the pixel mux / score logic.

Parameters:
- SCREEN_W, 640, visible width in pixels
- SCREEN_H, 480, visible height in pixels
- FISH_W, 32, fish bounding-box width
- FISH_H, 16, fish bounding-box height
- REEL_STEP, 2, rows moved up per hm pulse while hooked

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- h  in  10  current VGA pixel column
- v  in  10  current VGA pixel row
- way  in  2  0 = swim left, 1 = swim right, 2 = swim up, 3 = hold still
- appear  in  1  1 = fish exists; 0 = remove fish
- hm  in  3  horizontal step this cycle (0..7 px)
- vm  in  3  vertical step this cycle (0..7 px)
- spawn_x  in  10  start column, latched on spawn
- spawn_y  in  10  start row, latched on spawn
- hook_x  in  10  hook tip column
- hook_y  in  10  hook tip row
- hook_valid  in  1  hook is in the water
- fish_x  out  10  top-left column
- fish_y  out  10  top-left row
- active  out  1  fish on screen (state SWIM or HOOKED)
- in_fish  out  1  registered: (h,v) inside fish box
- caught  out  1  one-cycle pulse on hook capture
- landed  out  1  one-cycle pulse when hooked fish reaches row 0
- escaped  out  1  one-cycle pulse when fish leaves screen

Behaviour:
- States: IDLE, SWIM, HOOKED. State register uses asynchronous reset.
- Reset values: state IDLE; fish_x, fish_y, in_fish, caught, landed and escaped all 0; active 0.
- IDLE:
  - On appear=1, latch spawn_x/spawn_y into fish_x/fish_y and go to SWIM next cycle.
  - The latch is clamped: x to SCREEN_W-FISH_W, y to SCREEN_H-FISH_H.
- SWIM, per-cycle priority (highest first):
  1. appear=0 -> IDLE, no pulse.
  2. Capture: hook_valid and hook inside box, i.e. hook_x in [fish_x, fish_x+FISH_W) and hook_y in [fish_y, fish_y+FISH_H). Result: caught=1 for one cycle, go to HOOKED, no position update this cycle.
  3. Boundary: way=0 and hm > fish_x, or way=1 and fish_x+hm > SCREEN_W-FISH_W, or way=2 and vm > fish_y. Result: escaped=1 for one cycle, go to IDLE, position frozen.
  4. Move: way=0 gives x-=hm; way=1 gives x+=hm; way=2 gives y-=vm; way=3 holds. The vm input is ignored for way 0/1.
- Arithmetic:
  - All compares are done at 11 bits, so underflow/overflow cannot occur.
  - hm=0 / vm=0 gives no move and no boundary trigger.
- HOOKED:
  - x frozen.
  - Each cycle with hm!=0: y -= REEL_STEP, saturating at 0.
  - When y reaches 0 (compared against the updated value), landed=1 for one cycle and go to IDLE.
  - appear=0 -> IDLE, no pulse. hook_valid dropping has no effect.
- Pulses:
  - caught, landed and escaped are mutually exclusive, registered, and high for exactly one clock.
- in_fish:
  - Registered, one-cycle latency from h/v.
  - in_fish = active & h in [fish_x, fish_x+FISH_W) & v in [fish_y, fish_y+FISH_H).
- appear toggling 0->1 in the same cycle as an escape re-spawns on the following cycle (IDLE seen first).
- Reset mid-operation returns to IDLE immediately, asynchronously.

Optional Feature:
- FISH_WRAP_EN
- Defined: the SWIM boundary condition wraps instead of escaping. Moving left past 0 loads x=SCREEN_W-FISH_W; moving right past the edge loads x=0; moving up past 0 loads y=SCREEN_H-FISH_H. escaped is never asserted (tied 0).
- Undefined: escape behaviour as above.

Decomposition:
- Shared package fish_pkg:
  - state encoding (IDLE=0, SWIM=1, HOOKED=2)
  - way codes (WAY_LEFT/RIGHT/UP/HOLD)
  - SCREEN_W/SCREEN_H defaults
- Natural sub-module fish_box_hit: combinational point-in-rectangle test, used twice (hook capture and pixel in_fish).

Test Plan:
- Spawn: rst, then appear=1, spawn=(100,200) -> next cycle active=1, fish_x=100, fish_y=200; spawn_x=700 -> fish_x clamped to 608.
- Swim right: way=1, hm=3 for 10 cycles from x=100 -> fish_x=130, fish_y unchanged, no pulses.
- Escape left: x=5, way=0, hm=6 -> escaped one-cycle pulse, state IDLE, active=0, fish_x stays 5. With FISH_WRAP_EN: fish_x=608, escaped=0.
- Catch and land: fish at (200,20), hook_valid=1, hook=(210,25) -> caught pulse, no move that cycle. Then hm=1 for 10 cycles -> y=0 and landed pulse, active=0.
- Priority: catch and boundary in the same cycle -> caught only. appear=0 while HOOKED -> IDLE, no pulses.
- Pixel: fish at (64,64); h=64,v=64 -> in_fish=1 one cycle later; h=96 -> 0; v=79 -> 1; active=0 -> 0.
